// File: rtl/i2c_apb_regs_pkg.sv
// Shared definitions for the APB register bank in front of i2c_top.
// Holds register byte offsets, STATUS/CMD/IRQ bit indices, the access FSM
// encodings and the address decoder used by the top level.
package i2c_apb_regs_pkg;

  // Register byte offsets
  localparam logic [7:0] REG_PRESCALE = 8'h00;
  localparam logic [7:0] REG_CMD      = 8'h04;
  localparam logic [7:0] REG_SADDR    = 8'h08;
  localparam logic [7:0] REG_TX_DATA  = 8'h0C;
  localparam logic [7:0] REG_RX_DATA  = 8'h10;
  localparam logic [7:0] REG_STATUS   = 8'h14;
  localparam logic [7:0] REG_IRQ_STAT = 8'h18;
  localparam logic [7:0] REG_IRQ_EN   = 8'h1C;

  // STATUS bit indices (status_i)
  localparam int unsigned ST_TX_FULL  = 0;
  localparam int unsigned ST_TX_EMPTY = 1;
  localparam int unsigned ST_RX_FULL  = 2;
  localparam int unsigned ST_RX_EMPTY = 3;

  // CMD bit indices (command_o)
  localparam int unsigned CMD_RST_N   = 7;
  localparam int unsigned CMD_EN      = 6;
  localparam int unsigned CMD_RSTART  = 5;

  // IRQ_STAT / IRQ_EN bit indices
  localparam int unsigned IRQ_CORE    = 0;
  localparam int unsigned IRQ_TX_OVF  = 1;
  localparam int unsigned IRQ_RX_UNF  = 2;
  localparam int unsigned IRQ_W       = 3;

  // APB access FSM encodings
  localparam logic [1:0] FSM_IDLE   = 2'd0;
  localparam logic [1:0] FSM_ACCESS = 2'd1;
  localparam logic [1:0] FSM_RESP   = 2'd2;

  // Word index of each register; order matches the offsets above.
  typedef enum logic [2:0] {
    SEL_PRESCALE,
    SEL_CMD,
    SEL_SADDR,
    SEL_TX_DATA,
    SEL_RX_DATA,
    SEL_STATUS,
    SEL_IRQ_STAT,
    SEL_IRQ_EN
  } reg_sel_e;

  typedef struct packed {
    logic     bad;  // access must be rejected with pslverr and no side effect
    reg_sel_e sel;
  } reg_dec_t;

  // hi_zero: all address bits above the 32-byte window are zero.
  function automatic reg_dec_t decode_access(input logic       hi_zero,
                                             input logic [4:0] off,
                                             input logic       write);
    reg_dec_t dec;
    dec.sel = reg_sel_e'(off[4:2]);
    dec.bad = !hi_zero || (off[1:0] != 2'b00) ||
              (write && (dec.sel == SEL_RX_DATA || dec.sel == SEL_STATUS));
    return dec;
  endfunction

endpackage

// File: rtl/i2c_apb_regs_irq.sv
// Interrupt aggregation for the APB register bank.
// Detects rising edges of the core interrupt level, keeps sticky W1C status
// bits (core, TX overflow, RX underflow), masks them with the enable bits and
// produces a registered interrupt line.
// Ports:
//   clk, reset   - clock and synchronous active-high reset
//   interrupt    - core interrupt level
//   set_tx_ovf   - one-cycle TX overflow event
//   set_rx_unf   - one-cycle RX underflow event
//   clr_en       - IRQ_STAT write this cycle
//   clr_mask     - write-1-to-clear bits
//   irq_en       - enable mask
//   irq_stat     - sticky status bits
//   irq          - registered masked OR of irq_stat
module i2c_apb_irq
  import i2c_apb_regs_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             interrupt,
  input  logic             set_tx_ovf,
  input  logic             set_rx_unf,
  input  logic             clr_en,
  input  logic [IRQ_W-1:0] clr_mask,
  input  logic [IRQ_W-1:0] irq_en,
  output logic [IRQ_W-1:0] irq_stat,
  output logic             irq
);

  logic             interrupt_dly;
  logic [IRQ_W-1:0] set_bits;
  logic [IRQ_W-1:0] stat_next;

  always_comb begin
    set_bits             = '0;
    set_bits[IRQ_CORE]   = interrupt & ~interrupt_dly;
    set_bits[IRQ_TX_OVF] = set_tx_ovf;
    set_bits[IRQ_RX_UNF] = set_rx_unf;
    stat_next            = irq_stat;
    if (clr_en) begin
      stat_next = stat_next & ~clr_mask;
    end
    // Setting is applied after clearing so a coincident event is not lost.
    stat_next = stat_next | set_bits;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      interrupt_dly <= 1'b0;
      irq_stat      <= '0;
      irq           <= 1'b0;
    end else begin
      interrupt_dly <= interrupt;
      irq_stat      <= stat_next;
      irq           <= |(irq_stat & irq_en);
    end
  end

endmodule

// File: rtl/i2c_apb_regs.sv
// APB3 slave register bank feeding i2c_top.
// Every transfer takes one wait state: setup (IDLE), ACCESS (pready low, all
// side effects committed at the end of the cycle), RESP (pready high, read
// data and error valid). Core-facing outputs and strobes are registered.
// Ports:
//   APB_clk_i, APB_reset_i        - clock, synchronous active-high reset
//   psel_i..pwdata_i              - APB request
//   prdata_o, pready_o, pslverr_o - APB response
//   prescale_o, command_o, slave_addr_rw_o, data_transmit_o - core config
//   tx_push_o, rx_pop_o           - one-cycle FIFO strobes
//   data_receive_i, status_i      - RX FIFO head and FIFO flags
//   interrupt_i, irq_o            - core interrupt in, masked sticky irq out
module i2c_apb_regs
  import i2c_apb_regs_pkg::*;
#(
  parameter int unsigned ADDR_W       = 8,
  parameter int unsigned DATA_W       = 32,
  parameter logic [7:0]  PRESCALE_RST = 8'd8
) (
  input  logic              APB_clk_i,
  input  logic              APB_reset_i,
  input  logic              psel_i,
  input  logic              penable_i,
  input  logic              pwrite_i,
  input  logic [ADDR_W-1:0] paddr_i,
  input  logic [DATA_W-1:0] pwdata_i,
  output logic [DATA_W-1:0] prdata_o,
  output logic              pready_o,
  output logic              pslverr_o,
  output logic [7:0]        prescale_o,
  output logic [7:0]        command_o,
  output logic [7:0]        slave_addr_rw_o,
  output logic [7:0]        data_transmit_o,
  output logic              tx_push_o,
  output logic              rx_pop_o,
  input  logic [7:0]        data_receive_i,
  input  logic [7:0]        status_i,
  input  logic              interrupt_i,
  output logic              irq_o
);

  logic [1:0]       state;
  logic [1:0]       state_next;
  logic             commit;
  reg_dec_t         dec;
  logic [7:0]       wbyte;
  logic [7:0]       rdata;
  logic             err;
  logic             wr_prescale;
  logic             wr_cmd;
  logic             wr_saddr;
  logic             wr_irq_en;
  logic             irq_clr_en;
  logic             push_next;
  logic             pop_next;
  logic             set_tx_ovf;
  logic             set_rx_unf;
  logic [IRQ_W-1:0] irq_stat;
  logic [IRQ_W-1:0] irq_en;
  logic             unused_pwdata;

  assign unused_pwdata = ^pwdata_i[DATA_W-1:8];
  assign wbyte         = pwdata_i[7:0];
  assign pready_o      = (state == FSM_RESP);
  // Dropping psel in ACCESS is a protocol violation: abandon silently.
  assign commit        = (state == FSM_ACCESS) && psel_i;
  assign dec           = decode_access((paddr_i >> 5) == '0, paddr_i[4:0], pwrite_i);

  always_comb begin
    state_next = state;
    unique case (state)
      FSM_IDLE:   if (psel_i && !penable_i) state_next = FSM_ACCESS;
      FSM_ACCESS: state_next = psel_i ? FSM_RESP : FSM_IDLE;
      FSM_RESP:   state_next = FSM_IDLE;
      default:    state_next = FSM_IDLE;
    endcase
  end

  // Decide the outcome of the access being committed this cycle.
  always_comb begin
    rdata       = 8'h00;
    err         = 1'b0;
    wr_prescale = 1'b0;
    wr_cmd      = 1'b0;
    wr_saddr    = 1'b0;
    wr_irq_en   = 1'b0;
    irq_clr_en  = 1'b0;
    push_next   = 1'b0;
    pop_next    = 1'b0;
    set_tx_ovf  = 1'b0;
    set_rx_unf  = 1'b0;
    if (commit) begin
      if (dec.bad) begin
        err = 1'b1;
      end else if (pwrite_i) begin
        unique case (dec.sel)
          SEL_PRESCALE: wr_prescale = 1'b1;
          SEL_CMD:      wr_cmd      = 1'b1;
          SEL_SADDR:    wr_saddr    = 1'b1;
          SEL_TX_DATA: begin
            if (status_i[ST_TX_FULL]) begin
              err        = 1'b1;
              set_tx_ovf = 1'b1;
            end else begin
              push_next  = 1'b1;
            end
          end
          SEL_IRQ_STAT: irq_clr_en = 1'b1;
          SEL_IRQ_EN:   wr_irq_en  = 1'b1;
          SEL_RX_DATA, SEL_STATUS: ;  // rejected by the decoder
        endcase
      end else begin
        unique case (dec.sel)
          SEL_PRESCALE: rdata = prescale_o;
          SEL_CMD:      rdata = command_o;
          SEL_SADDR:    rdata = slave_addr_rw_o;
          SEL_TX_DATA:  rdata = data_transmit_o;
          SEL_RX_DATA: begin
            if (status_i[ST_RX_EMPTY]) begin
              err        = 1'b1;
              set_rx_unf = 1'b1;
            end else begin
              rdata      = data_receive_i;
              pop_next   = 1'b1;
            end
          end
          SEL_STATUS:   rdata = status_i;
          SEL_IRQ_STAT: rdata = {{(8-IRQ_W){1'b0}}, irq_stat};
          SEL_IRQ_EN:   rdata = {{(8-IRQ_W){1'b0}}, irq_en};
        endcase
      end
    end
  end

  always_ff @(posedge APB_clk_i) begin
    if (APB_reset_i) begin
      state           <= FSM_IDLE;
      prdata_o        <= '0;
      pslverr_o       <= 1'b0;
      prescale_o      <= PRESCALE_RST;
      command_o       <= 8'h00;
      slave_addr_rw_o <= 8'h00;
      data_transmit_o <= 8'h00;
      tx_push_o       <= 1'b0;
      rx_pop_o        <= 1'b0;
      irq_en          <= '0;
    end else begin
      state     <= state_next;
      tx_push_o <= push_next;
      rx_pop_o  <= pop_next;
      pslverr_o <= commit && err;
      if (commit) begin
        prdata_o <= {{(DATA_W-8){1'b0}}, rdata};
      end
      if (wr_prescale) prescale_o      <= wbyte;
      if (wr_cmd)      command_o       <= wbyte;
      if (wr_saddr)    slave_addr_rw_o <= wbyte;
      if (push_next)   data_transmit_o <= wbyte;
      if (wr_irq_en)   irq_en          <= wbyte[IRQ_W-1:0];
    end
  end

  i2c_apb_irq u_irq (
    .clk        (APB_clk_i),
    .reset      (APB_reset_i),
    .interrupt  (interrupt_i),
    .set_tx_ovf (set_tx_ovf),
    .set_rx_unf (set_rx_unf),
    .clr_en     (irq_clr_en),
    .clr_mask   (wbyte[IRQ_W-1:0]),
    .irq_en     (irq_en),
    .irq_stat   (irq_stat),
    .irq        (irq_o)
  );

endmodule

// File: tb/tb_i2c_apb_regs.sv
// Self-checking bench for i2c_apb_regs: a table of APB transfers with
// expected responses (queued as a scoreboard), plus hand-written sequences
// for interrupt timing, W1C/set collision and reset during a transfer.
module tb_i2c_apb_regs;

  logic        clk = 1'b0;
  logic        rst;
  logic        psel, penable, pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata, prdata;
  logic        pready, pslverr;
  logic [7:0]  prescale, command, saddr, dtx;
  logic        tx_push, rx_pop;
  logic [7:0]  data_receive, status;
  logic        interrupt, irq;

  always #5 clk = ~clk;

  i2c_apb_regs dut (
    .APB_clk_i       (clk),
    .APB_reset_i     (rst),
    .psel_i          (psel),
    .penable_i       (penable),
    .pwrite_i        (pwrite),
    .paddr_i         (paddr),
    .pwdata_i        (pwdata),
    .prdata_o        (prdata),
    .pready_o        (pready),
    .pslverr_o       (pslverr),
    .prescale_o      (prescale),
    .command_o       (command),
    .slave_addr_rw_o (saddr),
    .data_transmit_o (dtx),
    .tx_push_o       (tx_push),
    .rx_pop_o        (rx_pop),
    .data_receive_i  (data_receive),
    .status_i        (status),
    .interrupt_i     (interrupt),
    .irq_o           (irq)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [7:0]  wd;
    logic [7:0]  status;
    logic [7:0]  rx;
    logic [7:0]  exp_rd;
    logic        exp_err;
    int          exp_push;
    int          exp_pop;
    logic [31:0] exp_regs;  // {prescale, command, saddr, data_transmit} in RESP
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  function automatic vec_t mk(input logic wr, input logic [7:0] addr, input logic [7:0] wd,
                              input logic [7:0] st, input logic [7:0] rx,
                              input logic [7:0] rd, input logic e, input int pu, input int po,
                              input logic [31:0] regs);
    vec_t v;
    v.wr = wr; v.addr = addr; v.wd = wd; v.status = st; v.rx = rx;
    v.exp_rd = rd; v.exp_err = e; v.exp_push = pu; v.exp_pop = po; v.exp_regs = regs;
    return v;
  endfunction

  task automatic check(input string what, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", what, act, exp);
    end
  endtask

  // One APB transfer. waits counts cycles with pready low after setup;
  // strobes are counted over ACCESS, RESP and the following cycle.
  task automatic apb(input logic wr, input logic [7:0] addr, input logic [7:0] wd,
                     input logic raise, output logic [31:0] rd, output logic err,
                     output int waits, output int pushes, output int pops,
                     output logic [31:0] regs);
    waits = 0; pushes = 0; pops = 0;
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = {24'hA5C3E1, wd};
    @(posedge clk); #1;
    penable = 1'b1;
    if (raise) interrupt = 1'b1;
    while (!pready && waits < 8) begin
      pushes += int'(tx_push); pops += int'(rx_pop); waits++;
      @(posedge clk); #1;
    end
    rd = prdata; err = pslverr; regs = {prescale, command, saddr, dtx};
    pushes += int'(tx_push); pops += int'(rx_pop);
    psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    pushes += int'(tx_push); pops += int'(rx_pop);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd, regs;
    logic        err;
    int          waits, pushes, pops;
    vec_t        v, e;

    rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = 8'h00; pwdata = '0;
    data_receive = 8'h00; status = 8'h0A; interrupt = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("reset prescale", {24'h0, prescale}, 32'h08);
    check("reset command", {24'h0, command}, 32'h00);
    check("reset saddr", {24'h0, saddr}, 32'h00);
    check("reset data_transmit", {24'h0, dtx}, 32'h00);
    check("reset ctrl", {26'h0, pready, pslverr, tx_push, rx_pop, irq, 1'b0}, 32'h0);
    check("reset prdata", prdata, 32'h0);

    //             wr    addr   wd     status rx     rd     err   pu po regs
    vecs.push_back(mk(1'b0, 8'h00, 8'h00, 8'h0A, 8'h00, 8'h08, 1'b0, 0, 0, 32'h08000000));
    vecs.push_back(mk(1'b0, 8'h04, 8'h00, 8'h0A, 8'h00, 8'h00, 1'b0, 0, 0, 32'h08000000));
    vecs.push_back(mk(1'b0, 8'h08, 8'h00, 8'h0A, 8'h00, 8'h00, 1'b0, 0, 0, 32'h08000000));
    vecs.push_back(mk(1'b0, 8'h0C, 8'h00, 8'h0A, 8'h00, 8'h00, 1'b0, 0, 0, 32'h08000000));
    vecs.push_back(mk(1'b0, 8'h1C, 8'h00, 8'h0A, 8'h00, 8'h00, 1'b0, 0, 0, 32'h08000000));
    vecs.push_back(mk(1'b0, 8'h18, 8'h00, 8'h0A, 8'h00, 8'h00, 1'b0, 0, 0, 32'h08000000));
    vecs.push_back(mk(1'b1, 8'h04, 8'hC0, 8'h0A, 8'h00, 8'h00, 1'b0, 0, 0, 32'h08C00000));
    vecs.push_back(mk(1'b1, 8'h08, 8'hCE, 8'h0A, 8'h00, 8'h00, 1'b0, 0, 0, 32'h08C0CE00));
    vecs.push_back(mk(1'b1, 8'h00, 8'h10, 8'h0A, 8'h00, 8'h00, 1'b0, 0, 0, 32'h10C0CE00));
    vecs.push_back(mk(1'b0, 8'h04, 8'h00, 8'h0A, 8'h00, 8'hC0, 1'b0, 0, 0, 32'h10C0CE00));
    vecs.push_back(mk(1'b0, 8'h08, 8'h00, 8'h0A, 8'h00, 8'hCE, 1'b0, 0, 0, 32'h10C0CE00));
    vecs.push_back(mk(1'b0, 8'h00, 8'h00, 8'h0A, 8'h00, 8'h10, 1'b0, 0, 0, 32'h10C0CE00));
    vecs.push_back(mk(1'b1, 8'h0C, 8'h31, 8'h0A, 8'h00, 8'h00, 1'b0, 1, 0, 32'h10C0CE31));
    vecs.push_back(mk(1'b0, 8'h0C, 8'h00, 8'h0A, 8'h00, 8'h31, 1'b0, 0, 0, 32'h10C0CE31));
    vecs.push_back(mk(1'b1, 8'h0C, 8'h55, 8'h01, 8'h00, 8'h00, 1'b1, 0, 0, 32'h10C0CE31));
    vecs.push_back(mk(1'b0, 8'h18, 8'h00, 8'h0A, 8'h00, 8'h02, 1'b0, 0, 0, 32'h10C0CE31));
    vecs.push_back(mk(1'b1, 8'h18, 8'h02, 8'h0A, 8'h00, 8'h00, 1'b0, 0, 0, 32'h10C0CE31));
    vecs.push_back(mk(1'b0, 8'h18, 8'h00, 8'h0A, 8'h00, 8'h00, 1'b0, 0, 0, 32'h10C0CE31));
    vecs.push_back(mk(1'b0, 8'h10, 8'h00, 8'h02, 8'hA5, 8'hA5, 1'b0, 0, 1, 32'h10C0CE31));
    vecs.push_back(mk(1'b0, 8'h10, 8'h00, 8'h08, 8'h5A, 8'h00, 1'b1, 0, 0, 32'h10C0CE31));
    vecs.push_back(mk(1'b0, 8'h18, 8'h00, 8'h0A, 8'h00, 8'h04, 1'b0, 0, 0, 32'h10C0CE31));
    vecs.push_back(mk(1'b1, 8'h18, 8'h04, 8'h0A, 8'h00, 8'h00, 1'b0, 0, 0, 32'h10C0CE31));
    vecs.push_back(mk(1'b0, 8'h14, 8'h00, 8'h5A, 8'h00, 8'h5A, 1'b0, 0, 0, 32'h10C0CE31));
    vecs.push_back(mk(1'b0, 8'h20, 8'h00, 8'h0A, 8'h00, 8'h00, 1'b1, 0, 0, 32'h10C0CE31));
    vecs.push_back(mk(1'b1, 8'h20, 8'h77, 8'h0A, 8'h00, 8'h00, 1'b1, 0, 0, 32'h10C0CE31));
    vecs.push_back(mk(1'b1, 8'h02, 8'h77, 8'h0A, 8'h00, 8'h00, 1'b1, 0, 0, 32'h10C0CE31));
    vecs.push_back(mk(1'b1, 8'h14, 8'h77, 8'h0A, 8'h00, 8'h00, 1'b1, 0, 0, 32'h10C0CE31));
    vecs.push_back(mk(1'b1, 8'h10, 8'h77, 8'h0A, 8'h00, 8'h00, 1'b1, 0, 0, 32'h10C0CE31));
    vecs.push_back(mk(1'b0, 8'h00, 8'h00, 8'h0A, 8'h00, 8'h10, 1'b0, 0, 0, 32'h10C0CE31));
    vecs.push_back(mk(1'b1, 8'h1C, 8'h05, 8'h0A, 8'h00, 8'h00, 1'b0, 0, 0, 32'h10C0CE31));
    vecs.push_back(mk(1'b0, 8'h1C, 8'h00, 8'h0A, 8'h00, 8'h05, 1'b0, 0, 0, 32'h10C0CE31));
    vecs.push_back(mk(1'b1, 8'h1C, 8'h01, 8'h0A, 8'h00, 8'h00, 1'b0, 0, 0, 32'h10C0CE31));

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      status = v.status;
      data_receive = v.rx;
      sb.push_back(v);
      apb(v.wr, v.addr, v.wd, 1'b0, rd, err, waits, pushes, pops, regs);
      e = sb.pop_front();
      if (!e.wr) check($sformatf("vec%0d prdata", i), rd, {24'h0, e.exp_rd});
      check($sformatf("vec%0d pslverr", i), {31'h0, err}, {31'h0, e.exp_err});
      check($sformatf("vec%0d wait states", i), waits, 1);
      check($sformatf("vec%0d tx_push cycles", i), pushes, e.exp_push);
      check($sformatf("vec%0d rx_pop cycles", i), pops, e.exp_pop);
      check($sformatf("vec%0d regs in RESP", i), regs, e.exp_regs);
      check($sformatf("vec%0d irq", i), {31'h0, irq}, 32'h0);
    end
    status = 8'h0A;

    // Core interrupt rise with IRQ_EN=0x01: irq two cycles after the rise.
    @(posedge clk); #1 interrupt = 1'b1;
    @(posedge clk); #1 check("irq 1 cycle after rise", {31'h0, irq}, 32'h0);
    @(posedge clk); #1 check("irq 2 cycles after rise", {31'h0, irq}, 32'h1);
    interrupt = 1'b0;
    apb(1'b0, 8'h18, 8'h00, 1'b0, rd, err, waits, pushes, pops, regs);
    check("irq_stat after rise", rd, 32'h01);
    apb(1'b1, 8'h18, 8'h01, 1'b0, rd, err, waits, pushes, pops, regs);
    check("irq after w1c", {31'h0, irq}, 32'h0);
    apb(1'b0, 8'h18, 8'h00, 1'b0, rd, err, waits, pushes, pops, regs);
    check("irq_stat after w1c", rd, 32'h00);

    // W1C landing in the same cycle as a new rise: the set wins.
    apb(1'b1, 8'h18, 8'h01, 1'b1, rd, err, waits, pushes, pops, regs);
    apb(1'b0, 8'h18, 8'h00, 1'b0, rd, err, waits, pushes, pops, regs);
    check("irq_stat set beats clear", rd, 32'h01);
    check("irq after set beats clear", {31'h0, irq}, 32'h1);
    interrupt = 1'b0;
    apb(1'b1, 8'h18, 8'h01, 1'b0, rd, err, waits, pushes, pops, regs);
    check("irq cleared again", {31'h0, irq}, 32'h0);

    // Reset asserted during ACCESS of a TX write.
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h0C; pwdata = 32'h99;
    @(posedge clk); #1;
    penable = 1'b1; rst = 1'b1;
    check("pready low in ACCESS", {31'h0, pready}, 32'h0);
    @(posedge clk); #1;
    check("abort tx_push", {31'h0, tx_push}, 32'h0);
    check("abort pready", {31'h0, pready}, 32'h0);
    check("abort pslverr", {31'h0, pslverr}, 32'h0);
    check("abort prdata", prdata, 32'h0);
    check("abort regs", {prescale, command, saddr, dtx}, 32'h08000000);
    check("abort irq", {31'h0, irq}, 32'h0);
    psel = 1'b0; penable = 1'b0; rst = 1'b0;
    @(posedge clk); #1 check("abort tx_push later", {31'h0, tx_push}, 32'h0);
    apb(1'b0, 8'h00, 8'h00, 1'b0, rd, err, waits, pushes, pops, regs);
    check("prescale after abort", rd, 32'h08);
    apb(1'b0, 8'h1C, 8'h00, 1'b0, rd, err, waits, pushes, pops, regs);
    check("irq_en after abort", rd, 32'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
